// File: rtl/apb_pkg.sv
// apb_pkg: definitions shared by the APB slave, bus decoder and response mux.
// Holds the slave FSM encoding, default bus widths and the wait-counter width.
package apb_pkg;

   localparam int unsigned APB_DATA_WIDTH = 8;
   localparam int unsigned APB_ADDR_WIDTH = 8;
   localparam int unsigned APB_WAIT_CNT_W = 4;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } apb_state_e;

   // Index width for a register file of n entries (at least one bit).
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/apb_reg_file.sv
// apb_reg_file: register storage for the APB slave, one write port with
// enable and a combinational read port; entries clear on reset.
module apb_reg_file #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_REGS   = 4,
   parameter int unsigned IDX_W      = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  we_i,
   input  logic [IDX_W-1:0]      widx_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [IDX_W-1:0]      ridx_i,
   output logic [DATA_WIDTH-1:0] rdata_c_o
);

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i && (32'(widx_i) < NUM_REGS)) begin
         regs_q[widx_i] <= wdata_i;
      end
   end

   // Indices past the last entry read as zero.
   always_comb begin
      rdata_c_o = '0;
      if (32'(ridx_i) < NUM_REGS) begin
         rdata_c_o = regs_q[ridx_i];
      end
   end

endmodule

// File: rtl/apb_slave_regs.sv
// apb_slave_regs: APB register slave with programmable wait states.
// Define APB_SLAVE_REGS_SLVERR_EN to answer out-of-range indices with PSLVERR.
module apb_slave_regs
   import apb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = APB_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH  = APB_ADDR_WIDTH,
   parameter int unsigned NUM_REGS    = 4,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR
);

   localparam int unsigned IDX_W = idx_width(NUM_REGS);
   localparam int unsigned CNT_W = APB_WAIT_CNT_W;
   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

   apb_state_e            state_q,   state_d;
   logic [CNT_W-1:0]      cnt_q,     cnt_d;
   logic                  pready_q,  pready_d;
   logic                  pslverr_q, pslverr_d;
   logic [DATA_WIDTH-1:0] prdata_q,  prdata_d;
   logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
   logic                  write_q,   write_d;
   logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;

   logic                  setup_c;
   logic                  we_c;
   logic                  err_c;
   logic                  write_src_c;
   logic [ADDR_WIDTH-1:0] addr_src_c;
   logic [IDX_W-1:0]      idx_c;
   logic [DATA_WIDTH-1:0] rdata_c;

   assign setup_c = PSEL & ~PENABLE;

   // In IDLE the live bus is decoded (setup cycle); in ACCESS the captured request.
   assign addr_src_c  = (state_q == ST_IDLE) ? PADDR  : addr_q;
   assign write_src_c = (state_q == ST_IDLE) ? PWRITE : write_q;

`ifdef APB_SLAVE_REGS_SLVERR_EN
   assign err_c = (addr_src_c >= ADDR_WIDTH'(NUM_REGS));
   assign idx_c = IDX_W'(addr_src_c);
`else
   assign err_c = 1'b0;
   assign idx_c = IDX_W'(addr_src_c % ADDR_WIDTH'(NUM_REGS));
`endif

   apb_reg_file #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .IDX_W      (IDX_W)
   ) u_reg_file (
      .clk_i     (PCLK),
      .rst_ni    (PRESETn),
      .we_i      (we_c),
      .widx_i    (idx_c),
      .wdata_i   (wdata_q),
      .ridx_i    (idx_c),
      .rdata_c_o (rdata_c)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pready_d  = pready_q;
      addr_d    = addr_q;
      write_d   = write_q;
      wdata_d   = wdata_q;
      we_c      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (setup_c) begin
               state_d = ST_ACCESS;
               addr_d  = PADDR;
               write_d = PWRITE;
               wdata_d = PWDATA;
               if (WAIT_STATES == 0) begin
                  cnt_d    = '0;
                  pready_d = 1'b1;
               end else begin
                  cnt_d    = WAIT_INIT;
                  pready_d = 1'b0;
               end
            end
         end
         ST_ACCESS: begin
            if (!PSEL) begin
               state_d  = ST_IDLE;
               cnt_d    = '0;
               pready_d = 1'b0;
            end else if (pready_q) begin
               if (PENABLE) begin
                  we_c     = write_q & ~err_c;
                  state_d  = ST_IDLE;
                  pready_d = 1'b0;
               end
            end else begin
               // Last decrement raises PREADY for the following cycle.
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  pready_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      pslverr_d = pready_d & err_c;
      prdata_d  = (pready_d && !write_src_c && !err_c) ? rdata_c : '0;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
         addr_q    <= addr_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
      end
   end

   assign PRDATA  = prdata_q;
   assign PREADY  = pready_q;
   assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regs.sv
// tb_apb_slave_regs: scoreboard bench for apb_slave_regs with three instances
// (WAIT_STATES 0, 1, 3) and a behavioural register model.
module tb_apb_slave_regs;

   localparam int unsigned NI = 3;
   localparam int unsigned NR = 4;

`ifdef APB_SLAVE_REGS_SLVERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct {
      int unsigned u;
      logic        wr;
      logic [7:0]  rdata;
      logic        err;
      int unsigned lat;
   } exp_t;

   logic       PCLK = 1'b0;
   logic       PRESETn;
   logic       psel    [NI];
   logic       penable [NI];
   logic       pwrite  [NI];
   logic [7:0] paddr   [NI];
   logic [7:0] pwdata  [NI];
   logic [7:0] prdata  [NI];
   logic       pready  [NI];
   logic       pslverr [NI];

   int unsigned ws_of [NI] = '{0, 1, 3};
   logic [7:0]  mem [NI][NR];
   exp_t        sb_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 PCLK = ~PCLK;

   apb_slave_regs #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_REGS(4), .WAIT_STATES(0)) u_dut0 (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(penable[0]),
      .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
      .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

   apb_slave_regs #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_REGS(4), .WAIT_STATES(1)) u_dut1 (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(penable[1]),
      .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
      .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

   apb_slave_regs #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_REGS(4), .WAIT_STATES(3)) u_dut3 (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[2]), .PENABLE(penable[2]),
      .PWRITE(pwrite[2]), .PADDR(paddr[2]), .PWDATA(pwdata[2]),
      .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: out-of-range indices error (when enabled) or wrap modulo NR.
   function automatic exp_t model(input int unsigned u, input logic wr,
                                  input logic [7:0] a, input logic [7:0] d);
      exp_t e;
      bit   bad;
      bad     = ERR_EN && (a >= NR);
      e.u     = u;
      e.wr    = wr;
      e.err   = bad;
      e.lat   = ws_of[u] + 1;
      e.rdata = 8'h00;
      if (!bad) begin
         if (wr) mem[u][a % NR] = d;
         else    e.rdata = mem[u][a % NR];
      end
      return e;
   endfunction

   task automatic idle(input int n);
      for (int u = 0; u < NI; u++) begin
         psel[u]    = 1'b0;
         penable[u] = 1'b0;
      end
      repeat (n) begin
         @(posedge PCLK);
         #1;
      end
   endtask

   // Starts at posedge+1 (setup cycle); returns at posedge+1 after completion.
   task automatic xfer(input int unsigned u, input logic wr, input logic [7:0] a,
                       input logic [7:0] d, input logic [7:0] alt_a, input logic [7:0] alt_d);
      int budget;
      sb_q.push_back(model(u, wr, a, d));
      psel[u] = 1'b1; penable[u] = 1'b0; pwrite[u] = wr; paddr[u] = a; pwdata[u] = d;
      @(posedge PCLK);
      #1;
      penable[u] = 1'b1; paddr[u] = alt_a; pwdata[u] = alt_d;
      budget = 0;
      do begin
         @(negedge PCLK);
         budget++;
      end while (!pready[u] && budget < 40);
      if (!pready[u]) begin
         n_tests++;
         n_fail++;
         $display("FAIL xfer_timeout u%0d: PREADY got 0 after %0d cycles, expected 1", u, budget);
         void'(sb_q.pop_back());
         psel[u] = 1'b0; penable[u] = 1'b0;
      end
      @(posedge PCLK);
      #1;
   endtask

   task automatic abort_xfer(input int unsigned u, input logic wr, input logic [7:0] a,
                             input logic [7:0] d, input int n_acc);
      psel[u] = 1'b1; penable[u] = 1'b0; pwrite[u] = wr; paddr[u] = a; pwdata[u] = d;
      @(posedge PCLK);
      #1;
      penable[u] = 1'b1;
      repeat (n_acc) begin
         @(posedge PCLK);
         #1;
      end
      psel[u] = 1'b0; penable[u] = 1'b0;
   endtask

   // Monitor: protocol invariants every cycle, scoreboard pop on completion.
   initial begin : monitor
      int unsigned acc [NI];
      exp_t        e;
      for (int u = 0; u < NI; u++) acc[u] = 0;
      forever begin
         @(negedge PCLK);
         for (int u = 0; u < NI; u++) begin
            if (PRESETn !== 1'b1) begin
               acc[u] = 0;
               continue;
            end
            if (psel[u] && penable[u]) acc[u]++;
            else                       acc[u] = 0;
            if (pready[u]) begin
               check($sformatf("pready_outside_access u%0d", u),
                     32'({psel[u], penable[u]}), 32'd3);
            end else begin
               check($sformatf("prdata_not_ready u%0d", u), prdata[u], 0);
               check($sformatf("pslverr_not_ready u%0d", u), pslverr[u], 0);
            end
            if (psel[u] && penable[u] && pready[u]) begin
               if (sb_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_completion u%0d: got a completion, expected none", u);
               end else begin
                  e = sb_q.pop_front();
                  check($sformatf("completion_instance u%0d", u), u, e.u);
                  check($sformatf("latency u%0d", u), acc[u], e.lat);
                  check($sformatf("pslverr u%0d", u), pslverr[u], e.err);
                  if (!e.wr) check($sformatf("prdata u%0d", u), prdata[u], e.rdata);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no end of run, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int unsigned u;
      logic        wr;
      logic [7:0]  a, d;
      PRESETn = 1'b0;
      for (int i = 0; i < NI; i++) begin
         psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
         paddr[i] = 8'h00; pwdata[i] = 8'h00;
         for (int r = 0; r < NR; r++) mem[i][r] = 8'h00;
      end
      repeat (3) @(posedge PCLK);
      #1;
      for (int i = 0; i < NI; i++) begin
         check($sformatf("reset_pready u%0d", i), pready[i], 0);
         check($sformatf("reset_prdata u%0d", i), prdata[i], 0);
         check($sformatf("reset_pslverr u%0d", i), pslverr[i], 0);
      end
      @(negedge PCLK) PRESETn = 1'b1;
      @(posedge PCLK);
      #1;

      for (int i = 0; i < NI; i++)
         for (int r = 0; r < NR; r++) begin
            xfer(i, 1'b0, 8'(r), 8'h00, 8'(r), 8'h00);
            idle(1);
         end

      // Write/read with one wait state.
      xfer(1, 1'b1, 8'd2, 8'hA5, 8'd2, 8'hA5); idle(1);
      xfer(1, 1'b0, 8'd2, 8'h00, 8'd2, 8'h00); idle(1);

      // Zero wait states, back-to-back write then read.
      xfer(0, 1'b1, 8'd0, 8'h11, 8'd0, 8'h11);
      xfer(0, 1'b0, 8'd0, 8'h00, 8'd0, 8'h00); idle(1);

      // Abort after two access cycles: no completion, no write.
      abort_xfer(2, 1'b1, 8'd1, 8'h5A, 2); idle(2);
      xfer(2, 1'b0, 8'd1, 8'h00, 8'd1, 8'h00); idle(1);

      // Out-of-range index.
      xfer(0, 1'b1, 8'd7, 8'hFF, 8'd7, 8'hFF); idle(1);
      xfer(0, 1'b0, 8'd3, 8'h00, 8'd3, 8'h00);
      xfer(0, 1'b0, 8'd7, 8'h00, 8'd7, 8'h00); idle(1);

      // Request changed during access phase must be ignored.
      xfer(1, 1'b1, 8'd0, 8'h22, 8'd1, 8'h77); idle(1);
      xfer(1, 1'b0, 8'd0, 8'h00, 8'd0, 8'h00);
      xfer(1, 1'b0, 8'd1, 8'h00, 8'd1, 8'h00); idle(1);

      // Asynchronous reset mid-wait with a read completing on another instance.
      psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 8'd0;
      psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 8'd3; pwdata[2] = 8'h3C;
      @(posedge PCLK);
      #1;
      penable[0] = 1'b1; penable[2] = 1'b1;
      #1;
      check("pre_reset_pready u0", pready[0], 1);
      check("pre_reset_prdata u0", prdata[0], mem[0][0]);
      #1;
      PRESETn = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) begin
         check($sformatf("async_reset_pready u%0d", i), pready[i], 0);
         check($sformatf("async_reset_prdata u%0d", i), prdata[i], 0);
         check($sformatf("async_reset_pslverr u%0d", i), pslverr[i], 0);
         psel[i] = 1'b0; penable[i] = 1'b0;
         for (int r = 0; r < NR; r++) mem[i][r] = 8'h00;
      end
      repeat (2) @(posedge PCLK);
      @(negedge PCLK) PRESETn = 1'b1;
      @(posedge PCLK);
      #1;
      xfer(2, 1'b0, 8'd3, 8'h00, 8'd3, 8'h00); idle(1);
      xfer(0, 1'b0, 8'd0, 8'h00, 8'd0, 8'h00); idle(1);

      // Randomized traffic across instances.
      for (int k = 0; k < 120; k++) begin
         u  = $urandom_range(0, NI - 1);
         wr = 1'($urandom_range(0, 1));
         a  = 8'($urandom_range(0, 7));
         d  = 8'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            psel[u] = 1'b1; penable[u] = 1'b1;
            @(posedge PCLK);
            #1;
         end
         if (u == 2 && $urandom_range(0, 4) == 0) begin
            abort_xfer(u, wr, a, d, $urandom_range(0, 2));
         end else begin
            xfer(u, wr, a, d, 8'($urandom), 8'($urandom));
         end
         if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 2));
      end

      idle(5);
      check("scoreboard_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_slave_regs.md
APB_SLAVE_REGS -- requirements
Module: apb_slave_regs

Interface
REQ-001 Parameters SHALL be exactly, one per line (name, default, meaning):
  DATA_WIDTH, 8, width of PWDATA/PRDATA and each register
  ADDR_WIDTH, 8, width of PADDR
  NUM_REGS, 4, number of registers; word index = PADDR[ADDR_WIDTH-1:0], registers at index 0..NUM_REGS-1
  WAIT_STATES, 1, access-phase cycles with PREADY low before completion (0..15)
REQ-002 Ports SHALL be exactly (name direction width meaning):
  PCLK  input  1  the single clock; all state on rising edge
  PRESETn  input  1  reset, asynchronous, active-low
  PSEL  input  1  slave select from decoder
  PENABLE  input  1  access-phase indicator
  PWRITE  input  1  1 = write, 0 = read
  PADDR  input  ADDR_WIDTH  register index
  PWDATA  input  DATA_WIDTH  write data
  PRDATA  output  DATA_WIDTH  read data, registered
  PREADY  output  1  transfer completion, registered
  PSLVERR  output  1  error response, registered

Function
REQ-003 FSM SHALL have states IDLE, ACCESS; IDLE->ACCESS on PSEL=1,PENABLE=0 (setup cycle); ACCESS->IDLE on completion edge or PSEL=0.
REQ-004 At setup edge: WAIT_STATES=0 sets PREADY=1; otherwise load wait counter with WAIT_STATES, PREADY=0.
REQ-005 Each ACCESS cycle with PREADY=0 SHALL decrement counter; counter reaching 0 sets PREADY=1 next cycle; PREADY high exactly WAIT_STATES+1 access cycles after setup, for exactly one cycle.
REQ-006 Completion edge = PSEL&PENABLE&PREADY; write SHALL commit PWDATA into register PADDR at that edge only; PREADY SHALL clear at that edge.
REQ-007 Reads: PRDATA SHALL equal register[PADDR] while PREADY=1, and 0 at all other times.
REQ-008 Address/write/data SHALL be captured at setup edge; changes during access phase ignored.
REQ-009 PSEL deasserted during ACCESS (abort): return to IDLE, PREADY=0, no write.
REQ-010 Back-to-back: setup cycle immediately after completion SHALL be accepted with no idle cycle.
REQ-011 PENABLE=1 in IDLE (protocol violation) SHALL be ignored; no state change.
REQ-012 PSLVERR SHALL only be high while PREADY=1.

Reset
REQ-013 PRESETn low SHALL asynchronously force IDLE, counter 0, all registers 0, PRDATA=0, PREADY=0, PSLVERR=0.
REQ-014 Reset during ACCESS SHALL discard pending write; first transfer after release starts from setup.

Configuration
REQ-015 Macro APB_SLAVE_REGS_SLVERR_EN defined: PADDR>=NUM_REGS SHALL complete with PSLVERR=1, PRDATA=0, write suppressed.
REQ-016 Macro undefined: PSLVERR tied 0; index = PADDR modulo NUM_REGS (NUM_REGS power of two).

Structure
REQ-017 Package apb_pkg SHALL hold FSM state encoding and DATA_WIDTH/ADDR_WIDTH defaults, shared with the bus decoder and response mux.
REQ-018 Storage SHALL be sub-module apb_reg_file (write enable, write index, write data, read index, read data); FSM and wait counter in top.

Verification
REQ-019 Write 0xA5 to index 2, WAIT_STATES=1 -> PREADY high 2nd access cycle, read index 2 returns PRDATA=0xA5 with PREADY.
REQ-020 WAIT_STATES=0, back-to-back write 0x11 idx0 then read idx0 -> each completes first access cycle, read returns 0x11.
REQ-021 WAIT_STATES=3, PSEL dropped after 2nd access cycle -> no PREADY pulse, register unchanged (0x00).
REQ-022 SLVERR_EN defined, write 0xFF to index 7 (NUM_REGS=4) -> PSLVERR=1 with PREADY, all registers still 0; undefined -> index 3 = 0xFF.
REQ-023 PRESETn low mid-wait of write 0x3C -> outputs 0 immediately, register stays 0x00 after release.
REQ-024 PADDR/PWDATA changed to 1/0x77 during access of write 0x22 idx0 -> idx0=0x22, idx1=0x00.
